// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Registered, back-pressurable immediate generator for the decode stage.
// The immediate is built combinationally from Inst[31:7] and ImmSrc on the
// input side. It is stored, together with the sideband tag, in a two-entry
// FIFO made of a head register and a skid register. The head register drives
// the outputs directly, so ImmExt/out_tag/illegal come straight from flops.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the sideband tag carried with each immediate
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      drops every buffered entry and any entry offered this cycle
//   in_valid   Inst/ImmSrc/in_tag are valid
//   in_ready   buffer has room (depends on occupancy only)
//   Inst       instruction bits [31:7]
//   ImmSrc     immediate format select
//   in_tag     sideband tag, returned unchanged with the result
//   out_valid  head entry is valid
//   out_ready  consumer takes the head entry this cycle
//   ImmExt     extended immediate of the head entry
//   out_tag    tag of the head entry
//   illegal    head entry used a reserved/illegal format
//              (present only when IMM_ILLEGAL_CHECK_EN is defined)
//
// Optional feature macro: IMM_ILLEGAL_CHECK_EN
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      Inst,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_CHECK_EN
    ,
    output logic             illegal
`endif
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // One buffered result: the final immediate plus everything that travels
    // with it.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_CHECK_EN
        logic             ill;
`endif
    } entry_t;

    // Buffer occupancy: empty, head only, head plus skid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t   state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;

    logic        accept;
    logic        pop;
    logic [31:7] ins;

    // Re-index the instruction field so the format table below can use the
    // architectural bit numbers.
    assign ins = Inst;

    // Immediate generation on the input side, so stored entries already hold
    // the final value. Sign extension uses a signed size cast.
    always_comb begin
        new_entry     = '0;
        new_entry.tag = in_tag;
        unique case (ImmSrc)
            3'b000: new_entry.imm = XLEN'($signed(ins[31:20]));
            3'b001: new_entry.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            3'b010: new_entry.imm = XLEN'($signed({ins[31], ins[7], ins[30:25],
                                                   ins[11:8], 1'b0}));
            3'b011: new_entry.imm = XLEN'($signed({ins[31], ins[19:12], ins[20],
                                                   ins[30:21], 1'b0}));
            3'b100: new_entry.imm = XLEN'($signed({ins[31:12], 12'b0}));
            3'b101: begin
                // RV64 shift amounts carry one more bit than RV32 ones.
                if (XLEN == 32) begin
                    new_entry.imm = XLEN'(ins[24:20]);
                end else begin
                    new_entry.imm = XLEN'(ins[25:20]);
                end
            end
            3'b110: new_entry.imm = XLEN'(ins[19:15]);
            default: new_entry.imm = '0;
        endcase
`ifdef IMM_ILLEGAL_CHECK_EN
        // Reserved select, or an RV32 shift amount with bit 5 set.
        new_entry.ill = (ImmSrc == 3'b111) ||
                        ((ImmSrc == 3'b101) && (XLEN == 32) && ins[25]);
`endif
    end

    // Handshake. in_ready is derived from occupancy alone so it never forms a
    // combinational path from out_ready.
    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy and data movement. The head only changes when it is popped
    // (or when the buffer is empty), which keeps the outputs stable under
    // back-pressure. Flush overrides everything; data registers are left as
    // they are because out_valid masks them.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_d  = new_entry;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = OCC_FULL;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
            endcase
        end
    end

    // State and storage registers; reset clears the visible outputs too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign ImmExt  = head_q.imm;
    assign out_tag = head_q.tag;
`ifdef IMM_ILLEGAL_CHECK_EN
    assign illegal = head_q.ill;
`endif

endmodule
